// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the fill value used for the divide-by-zero quotient.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Every quotient bit takes this value when the divisor is zero.
    localparam logic DBZ_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/seq_divider_subtractor.sv
// N-bit trial subtractor for the restoring divider: diff = a - b, formed as
// a + ~b + 1 so the carry out of the top bit doubles as a not-borrow flag.
module subtractor_n #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] sum;

    // One's-complement add with carry-in of one; a missing carry means a < b.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        diff   = sum[N-1:0];
        borrow = ~sum[N];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider. One quotient bit is resolved per
// clock; start/busy/done handshake towards the ALU control unit.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_e           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    // After every step R is below the divisor, so its top bit is always zero
    // and is discarded by the left shift; it is kept only for the full-width R.
    logic             unused_r_msb;

    assign unused_r_msb = r_q[WIDTH];

    // A request is taken whenever no operation is running (IDLE or DONE).
    assign accept    = start && (state_q != ST_RUN);
    assign last_iter = (cnt_q == CNT_ONE);

    // {R, Q} shifted left by one: the MSB of Q moves into the LSB of R.
    assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    subtractor_n #(
        .N(WIDTH + 1)
    ) u_sub (
        .a      (r_shift),
        .b      ({1'b0, d_q}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    // Restoring step: keep the difference only when the subtraction did not borrow.
    always_comb begin
        r_step = trial_borrow ? r_shift : trial_diff;
        q_step = {q_q[WIDTH-2:0], ~trial_borrow};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero divisor skips the iteration phase entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (divisor == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_iter) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: load on accept, iterate in RUN, publish on the last step.
    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        d_d    = d_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (accept) begin
            q_d   = dividend;
            d_d   = divisor;
            r_d   = '0;
            cnt_d = CNT_LOAD;
            dbz_d = 1'b0;
            if (divisor == '0) begin
                quot_d = {WIDTH{DBZ_QUOTIENT_BIT}};
                rem_d  = dividend;
                dbz_d  = 1'b1;
            end
        end else if (state_q == ST_RUN) begin
            q_d   = q_step;
            r_d   = r_step;
            cnt_d = cnt_q - CNT_ONE;
            if (last_iter) begin
                quot_d = q_step;
                rem_d  = r_step[WIDTH-1:0];
            end
        end
    end

    // Datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            d_q    <= d_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

    // Handshake outputs decoded from the state; results come straight from flops.
    always_comb begin
        busy        = (state_q == ST_RUN);
        done        = (state_q == ST_DONE);
        quotient    = quot_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH = 32): directed edge cases,
// handshake timing, reset behaviour and a randomized back-to-back regression
// compared with a plain-arithmetic reference model.
module tb_seq_divider;

    localparam int W       = 32;
    localparam int TIMEOUT = 100;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;

    int checkCount = 0;
    int errorCount = 0;
    int doneCount  = 0;

    seq_divider #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every cycle in which done is seen high.
    always @(negedge clk) begin
        if (done) doneCount++;
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issues one request from the current negedge, optionally pulses a second
    // start after injectAt cycles, waits for done (bounded) and checks the
    // result, latency and busy duration against the arithmetic model.
    task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int injectAt, input logic [W-1:0] ia,
                                 input logic [W-1:0] ib);
        int          lat;
        int          busyCycles;
        bit          gotDone;
        logic [W-1:0] expQ;
        logic [W-1:0] expR;
        int          expLat;
        int          expBusy;

        expQ    = (b == 0) ? {W{1'b1}} : a / b;
        expR    = (b == 0) ? a : a % b;
        expLat  = (b == 0) ? 1 : W + 1;
        expBusy = (b == 0) ? 0 : W;

        start    = 1'b1;
        dividend = a;
        divisor  = b;
        lat        = 0;
        busyCycles = 0;
        gotDone    = 1'b0;
        while (!gotDone && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
            start    = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
            if (lat == injectAt) begin
                start    = 1'b1;
                dividend = ia;
                divisor  = ib;
            end
            if (busy) busyCycles++;
            if (done) gotDone = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, 64'(gotDone), 64'd1);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, "_busy_cycles"}, 64'(busyCycles), 64'(expBusy));
        checkOutput({tag, "_quotient"}, 64'(quotient), 64'(expQ));
        checkOutput({tag, "_remainder"}, 64'(remainder), 64'(expR));
        checkOutput({tag, "_dbz"}, 64'(div_by_zero), 64'(b == 0));
    endtask

    // Short helper for a plain request with no injected second start.
    task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        applyStimulus(tag, a, b, -1, '0, '0);
    endtask

    initial begin
        int snap;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        checkOutput("reset_quotient", 64'(quotient), 64'd0);
        checkOutput("reset_remainder", 64'(remainder), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic and edge values.
        runOp("basic_100_7", 32'd100, 32'd7);
        @(negedge clk);
        checkOutput("done_single_pulse", 64'(done), 64'd0);
        runOp("max_div_1", 32'hFFFF_FFFF, 32'd1);
        runOp("small_3_10", 32'd3, 32'd10);
        runOp("msb_msb", 32'h8000_0000, 32'h8000_0000);

        // Divide by zero then a normal operation clears the flag.
        @(negedge clk);
        runOp("dbz_5_0", 32'd5, 32'd0);
        @(negedge clk);
        runOp("after_dbz_9_3", 32'd9, 32'd3);

        // Start while busy is ignored and yields a single done pulse.
        @(negedge clk);
        snap = doneCount;
        applyStimulus("ignored_start", 32'd50, 32'd5, 10, 32'd7, 32'd7);
        repeat (3) @(negedge clk);
        checkOutput("ignored_one_done", 64'(doneCount - snap), 64'd1);

        // Asynchronous reset in the middle of an operation.
        start    = 1'b1;
        dividend = 32'd200;
        divisor  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        checkOutput("midrun_busy", 64'(busy), 64'd1);
        snap  = doneCount;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        checkOutput("rst_async_quotient", 64'(quotient), 64'd0);
        checkOutput("rst_async_remainder", 64'(remainder), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("rst_no_done", 64'(doneCount - snap), 64'd0);
        checkOutput("rst_idle", 64'(busy), 64'd0);

        // Back-to-back: second start is driven during the done cycle.
        runOp("b2b_1000_33", 32'd1000, 32'd33);
        runOp("b2b_8_3", 32'd8, 32'd3);

        // Randomized back-to-back regression with mixed operand classes.
        for (int i = 0; i < 1200; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 255));
                2:       rb = ra;
                3:       rb = ra + W'($urandom_range(1, 1000));
                4:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = ra >> $urandom_range(0, 31);
            runOp("random", ra, rb);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
